// File: rtl/spi_slave_burst_if.sv
// rtl/spi_slave_burst_if.sv - SPI pins and register-file bus of spi_slave_burst
interface spi_slave_burst_if #(
    parameter int ASZ = 7,
    parameter int DSZ = 32
);
    logic           spi_sck;
    logic           spi_mosi;
    logic           spi_ncs;
    logic           spi_miso;
    logic           spi_miso_oe;
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] data_out;
    logic [DSZ-1:0] data_in;
    logic           wr_en;
    logic           rd_en;
    logic           busy;
    logic           abort;

    modport slave (
        input  spi_sck, spi_mosi, spi_ncs, data_in,
        output spi_miso, spi_miso_oe, addr, data_out, wr_en, rd_en, busy, abort
    );

    modport master (
        output spi_sck, spi_mosi, spi_ncs, data_in,
        input  spi_miso, spi_miso_oe, addr, data_out, wr_en, rd_en, busy, abort
    );
endinterface

// File: rtl/spi_slave_burst.sv
// rtl/spi_slave_burst.sv - oversampled SPI register-interface slave with bursts and auto-increment
module spi_slave_burst #(
    parameter int ASZ  = 7,
    parameter int DSZ  = 32,
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0,
    parameter bit AINC = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    spi_slave_burst_if.slave spi_bus
);
    localparam int CMAX = (ASZ > DSZ) ? ASZ : DSZ;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

    logic [1:0]     sck_sync_q, mosi_sync_q, ncs_sync_q;
    logic           sck_dly_q, ncs_dly_q;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rnw_q, rnw_d;
    logic [ASZ-1:0] addr_sh_q, addr_sh_d;
    logic [DSZ-1:0] rx_sr_q, rx_sr_d;
    logic [DSZ-1:0] tx_sr_q, tx_sr_d;
    logic [ASZ-1:0] addr_q, addr_d;
    logic [DSZ-1:0] data_out_q, data_out_d;
    logic           wr_pend_q, wr_pend_d;
    logic           wr_en_q, wr_en_d;
    logic           rd_en_q, rd_en_d;
    logic           rd_cap_q, rd_cap_d;
    logic           busy_q, busy_d;
    logic           abort_q, abort_d;
    logic           miso_q, miso_d;
    logic           miso_oe_q, miso_oe_d;

    logic           sck_s, mosi_s, ncs_s;
    logic           phase_now, phase_prev;
    logic           sample_edge, shift_edge;
    logic           ncs_fall, ncs_rise;
    logic [ASZ:0]   addr_shift;
    logic [DSZ:0]   rx_shift;

    assign sck_s  = sck_sync_q[1];
    assign mosi_s = mosi_sync_q[1];
    assign ncs_s  = ncs_sync_q[1];

    // Folding CPOL in makes "leading edge" always a rising phase edge.
    assign phase_now   = sck_s ^ CPOL;
    assign phase_prev  = sck_dly_q ^ CPOL;
    assign sample_edge = CPHA ? (~phase_now & phase_prev) : (phase_now & ~phase_prev);
    assign shift_edge  = CPHA ? (phase_now & ~phase_prev) : (~phase_now & phase_prev);

    assign ncs_fall = ~ncs_s & ncs_dly_q;
    assign ncs_rise = ncs_s & ~ncs_dly_q;

    assign addr_shift = {addr_sh_q, mosi_s};
    assign rx_shift   = {rx_sr_q, mosi_s};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rnw_d      = rnw_q;
        addr_sh_d  = addr_sh_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        addr_d     = addr_q;
        data_out_d = data_out_q;
        miso_d     = miso_q;
        wr_pend_d  = 1'b0;
        wr_en_d    = wr_pend_q;
        rd_en_d    = 1'b0;
        rd_cap_d   = rd_en_q;
        abort_d    = 1'b0;

        if (rd_cap_q) begin
            tx_sr_d = spi_bus.data_in;
        end
        if (wr_en_q && AINC) begin
            addr_d = addr_q + ASZ'(1);
        end

        if (ncs_s) begin
            state_d   = IDLE;
            cnt_d     = '0;
            rnw_d     = 1'b0;
            addr_sh_d = '0;
            rx_sr_d   = '0;
            tx_sr_d   = '0;
            miso_d    = 1'b0;
            if (ncs_rise && (state_q == CMD || state_q == ADDR ||
                             (state_q == DATA && cnt_q != '0))) begin
                abort_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (ncs_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (sample_edge) begin
                        rnw_d   = mosi_s;
                        state_d = ADDR;
                        cnt_d   = '0;
                    end
                end
                ADDR: begin
                    if (sample_edge) begin
                        addr_sh_d = addr_shift[ASZ-1:0];
                        if (cnt_q == CW'(ASZ - 1)) begin
                            addr_d  = addr_shift[ASZ-1:0];
                            state_d = DATA;
                            cnt_d   = '0;
                            rd_en_d = rnw_q;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                DATA: begin
                    if (shift_edge && rnw_q) begin
                        miso_d  = tx_sr_q[DSZ-1];
                        tx_sr_d = {tx_sr_q[DSZ-2:0], 1'b0};
                    end
                    if (sample_edge) begin
                        rx_sr_d = rx_shift[DSZ-1:0];
                        if (cnt_q == CW'(DSZ - 1)) begin
                            cnt_d = '0;
                            // Reads bump the address before the prefetch so rd_en names the next word.
                            if (rnw_q) begin
                                if (AINC) begin
                                    addr_d = addr_q + ASZ'(1);
                                end
                                rd_en_d = 1'b1;
                            end else begin
                                data_out_d = rx_shift[DSZ-1:0];
                                wr_pend_d  = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d    = (state_d != IDLE);
        miso_oe_d = busy_d;
    end

    // nCS sync resets low so a frame already running at reset release never shows a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= {2{CPOL}};
            mosi_sync_q <= 2'b00;
            ncs_sync_q  <= 2'b00;
            sck_dly_q   <= CPOL;
            ncs_dly_q   <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rnw_q       <= 1'b0;
            addr_sh_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            addr_q      <= '0;
            data_out_q  <= '0;
            wr_pend_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_cap_q    <= 1'b0;
            busy_q      <= 1'b0;
            abort_q     <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], spi_bus.spi_sck};
            mosi_sync_q <= {mosi_sync_q[0], spi_bus.spi_mosi};
            ncs_sync_q  <= {ncs_sync_q[0], spi_bus.spi_ncs};
            sck_dly_q   <= sck_s;
            ncs_dly_q   <= ncs_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rnw_q       <= rnw_d;
            addr_sh_q   <= addr_sh_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            addr_q      <= addr_d;
            data_out_q  <= data_out_d;
            wr_pend_q   <= wr_pend_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            rd_cap_q    <= rd_cap_d;
            busy_q      <= busy_d;
            abort_q     <= abort_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    assign spi_bus.spi_miso    = miso_q;
    assign spi_bus.spi_miso_oe = miso_oe_q;
    assign spi_bus.addr        = addr_q;
    assign spi_bus.data_out    = data_out_q;
    assign spi_bus.wr_en       = wr_en_q;
    assign spi_bus.rd_en       = rd_en_q;
    assign spi_bus.busy        = busy_q;
    assign spi_bus.abort       = abort_q;
endmodule
